// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset/NOP constants, branch opcodes.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    // funct3 encodings used by the execute-stage branch unit that drives br_taken
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction holding register: passes a fresh response straight to decode and
// keeps it stable while decode stalls; a redirect flushes it.
module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap,
    input  logic [31:0] cap_pc,
    input  logic [31:0] cap_instr,
    input  logic        stall,
    input  logic        flush,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
);

    logic        vld_q, vld_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        vld_d   = vld_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (cap) begin
            pc_d    = cap_pc;
            instr_d = cap_instr;
            vld_d   = stall;
        end else if (!stall) begin
            vld_d = 1'b0;
        end
        if (flush) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            vld_q   <= vld_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // A response is visible in its arrival cycle; the register covers the stall.
    assign if_valid    = (cap || vld_q) && !flush;
    assign if_pc       = cap ? cap_pc : pc_q;
    assign if_instr    = cap ? cap_instr : instr_q;
    assign if_pc_plus4 = pc_plus4(if_pc);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding imem requests, redirect/kill handling.
// Optional FETCH_MISALIGN_TRAP_EN adds misalign_exc and parks on misaligned redirect targets.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [31:0] new_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_exc
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         req_q, req_d;
    logic         park_q, park_d;

    logic         accepted;
    logic         resp;
    logic         b2b;
    logic         cap;
    logic         redirect_bad;
    logic [31:0]  target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic exc_q;

    assign redirect_bad = br_taken && (new_pc[1:0] != 2'b00);
    assign target       = new_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= redirect_bad;
        end
    end

    assign misalign_exc = exc_q;
`else
    assign redirect_bad = 1'b0;
    assign target       = new_pc & ~32'h0000_0003;
`endif

    // The next request may go out in the same cycle its predecessor's data returns,
    // which is what keeps one instruction per cycle with a 1-cycle memory.
    assign resp      = (state_q == ST_WAIT) && imem_rvalid && !kill_q;
    assign b2b       = resp && !br_taken && !stall;
    assign cap       = resp && !br_taken;
    assign imem_req  = req_q || b2b;
    assign imem_addr = b2b ? pc_plus4(pc_q) : pc_q;
    assign accepted  = imem_req && imem_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        park_d  = park_q;
        if (kill_q && imem_rvalid) begin
            kill_d = 1'b0;
        end
        if (br_taken) begin
            pc_d    = target;
            park_d  = redirect_bad;
            state_d = redirect_bad ? ST_IDLE : ST_REQ;
            kill_d  = (kill_q && !imem_rvalid)
                   || ((state_q == ST_REQ) && accepted)
                   || ((state_q == ST_WAIT) && !imem_rvalid);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!park_q) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (accepted) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp) begin
                        if (stall) begin
                            state_d = ST_HOLD;
                        end else begin
                            pc_d    = pc_plus4(pc_q);
                            state_d = imem_ready ? ST_WAIT : ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc_d    = pc_plus4(pc_q);
                        state_d = ST_REQ;
                    end
                end
            endcase
        end
        // A redirect target waits in REQ until the killed response drains.
        req_d = (state_d == ST_REQ) && !kill_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
            park_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
            park_q  <= park_d;
        end
    end

    fetch_buf #(
        .RESET_PC(RESET_PC)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .cap        (cap),
        .cap_pc     (pc_q),
        .cap_instr  (imem_rdata),
        .stall      (stall),
        .flush      (br_taken),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_pc_plus4(if_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus hand-written reset/misalign sequences.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] new_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_taken   (br_taken),
        .new_pc     (new_pc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_exc(misalign_exc)
`endif
    );

    // ctl = {br_taken, stall, imem_ready, imem_rvalid}; exp = {imem_req, if_valid}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] npc;
        logic [31:0] rdata;
        logic [1:0]  exp;
        logic [31:0] eaddr;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    localparam int NV = 30;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0010_0093;
    localparam logic [31:0] I1  = 32'h0020_0093;
    localparam logic [31:0] I2  = 32'h0030_0093;
    localparam logic [31:0] IA  = 32'h00A0_0093;
    localparam logic [31:0] I3  = 32'h0040_0093;
    localparam logic [31:0] I4  = 32'h0050_0093;
    localparam logic [31:0] I5  = 32'h0060_0093;

    vec_t vt[NV];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] npc,
                                input logic [31:0] rdata, input logic [1:0] exp,
                                input logic [31:0] eaddr, input logic [31:0] epc,
                                input logic [31:0] einstr);
        vec_t v;
        v.ctl = ctl; v.npc = npc; v.rdata = rdata; v.exp = exp;
        v.eaddr = eaddr; v.epc = epc; v.einstr = einstr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic br, input logic [31:0] npc, input logic stl,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        br_taken = br; new_pc = npc; stall = stl;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = mk(4'b0000, '0, '0, 2'b00, '0, '0, '0);
        vt[1]  = mk(4'b0010, '0, '0, 2'b10, 32'h0, '0, '0);
        vt[2]  = mk(4'b0011, '0, I0, 2'b11, 32'h4, 32'h0, I0);
        vt[3]  = mk(4'b0011, '0, I1, 2'b11, 32'h8, 32'h4, I1);
        vt[4]  = mk(4'b0011, '0, I2, 2'b11, 32'hC, 32'h8, I2);
        vt[5]  = mk(4'b0111, '0, IA, 2'b01, '0, 32'hC, IA);
        vt[6]  = mk(4'b0110, '0, '0, 2'b01, '0, 32'hC, IA);
        vt[7]  = mk(4'b0110, '0, '0, 2'b01, '0, 32'hC, IA);
        vt[8]  = mk(4'b0010, '0, '0, 2'b01, '0, 32'hC, IA);
        vt[9]  = mk(4'b0010, '0, '0, 2'b10, 32'h10, '0, '0);
        vt[10] = mk(4'b1010, 32'h100, '0, 2'b00, '0, '0, '0);
        vt[11] = mk(4'b0010, '0, '0, 2'b00, '0, '0, '0);
        vt[12] = mk(4'b0011, '0, 32'hDEAD_BEEF, 2'b00, '0, '0, '0);
        for (int k = 13; k <= 17; k++) begin
            vt[k] = mk(4'b0000, '0, '0, 2'b10, 32'h100, '0, '0);
        end
        vt[18] = mk(4'b0010, '0, '0, 2'b10, 32'h100, '0, '0);
        vt[19] = mk(4'b0001, '0, I3, 2'b11, 32'h104, 32'h100, I3);
        vt[20] = mk(4'b0010, '0, '0, 2'b10, 32'h104, '0, '0);
        vt[21] = mk(4'b1111, 32'h100, 32'hBAD0_BAD0, 2'b00, '0, '0, '0);
        vt[22] = mk(4'b0011, '0, 32'hBAD1_BAD1, 2'b10, 32'h100, '0, '0);
        vt[23] = mk(4'b0001, '0, I4, 2'b11, 32'h104, 32'h100, I4);
        vt[24] = mk(4'b1010, 32'hFFFF_FFFC, '0, 2'b10, 32'h104, '0, '0);
        vt[25] = mk(4'b0011, '0, 32'h0BAD_F00D, 2'b00, '0, '0, '0);
        vt[26] = mk(4'b0010, '0, '0, 2'b10, 32'hFFFF_FFFC, '0, '0);
        vt[27] = mk(4'b0001, '0, I5, 2'b11, 32'h0, 32'hFFFF_FFFC, I5);
        vt[28] = mk(4'b1000, 32'h102, '0, 2'b10, 32'h0, '0, '0);
`ifdef FETCH_MISALIGN_TRAP_EN
        vt[29] = mk(4'b0000, '0, '0, 2'b00, '0, '0, '0);
`else
        vt[29] = mk(4'b0000, '0, '0, 2'b10, 32'h100, '0, '0);
`endif

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_req", 32'(imem_req), 32'd0);
        chk("reset if_valid", 32'(if_valid), 32'd0);
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset if_instr", if_instr, NOP);
        chk("reset if_pc_plus4", if_pc_plus4, 32'h4);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].ctl[3], vt[i].npc, vt[i].ctl[2], vt[i].ctl[1], vt[i].ctl[0], vt[i].rdata);
            @(negedge clk);
            chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vt[i].exp[1]));
            if (vt[i].exp[1]) begin
                chk($sformatf("row%0d imem_addr", i), imem_addr, vt[i].eaddr);
            end
            chk($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(vt[i].exp[0]));
            if (vt[i].exp[0]) begin
                chk($sformatf("row%0d if_pc", i), if_pc, vt[i].epc);
                chk($sformatf("row%0d if_instr", i), if_instr, vt[i].einstr);
                chk($sformatf("row%0d if_pc_plus4", i), if_pc_plus4, vt[i].epc + 32'd4);
            end
            next_cycle();
        end

        // Reset while a request may be in flight, then its late response arrives.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        next_cycle();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        next_cycle();
        chk("midrst imem_req", 32'(imem_req), 32'd0);
        chk("midrst if_valid", 32'(if_valid), 32'd0);
        chk("midrst if_instr", if_instr, NOP);
        chk("midrst if_pc_plus4", if_pc_plus4, 32'h4);
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hCAFE_CAFE);
        @(negedge clk);
        chk("late rvalid if_valid", 32'(if_valid), 32'd0);
        chk("late rvalid imem_req", 32'(imem_req), 32'd0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("post-reset imem_req", 32'(imem_req), 32'd1);
        chk("post-reset imem_addr", imem_addr, 32'h0);
        next_cycle();

`ifdef FETCH_MISALIGN_TRAP_EN
        // In WAIT: misaligned redirect parks the fetcher until a good redirect.
        drive(1'b1, 32'h102, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("mis redirect if_valid", 32'(if_valid), 32'd0);
        chk("mis redirect exc low", 32'(misalign_exc), 32'd0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("mis exc", 32'(misalign_exc), 32'd1);
        chk("mis imem_req c1", 32'(imem_req), 32'd0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
        @(negedge clk);
        chk("mis exc pulse", 32'(misalign_exc), 32'd0);
        chk("mis imem_req c2", 32'(imem_req), 32'd0);
        chk("mis killed if_valid", 32'(if_valid), 32'd0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("mis imem_req c3", 32'(imem_req), 32'd0);
        next_cycle();
        drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("mis imem_req c4", 32'(imem_req), 32'd0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("mis recover imem_req", 32'(imem_req), 32'd1);
        chk("mis recover imem_addr", imem_addr, 32'h200);
        chk("mis recover exc", 32'(misalign_exc), 32'd0);
        next_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port br_taken  input  1  redirect request from the execute-stage branch unit.
REQ-005 SHALL have port new_pc  input  32  redirect target; valid only when br_taken=1.
REQ-006 SHALL have port stall  input  1  downstream (decode) cannot accept an instruction this cycle.
REQ-007 SHALL have ports imem_req output 1 / imem_addr output 32: instruction-memory request and word address.
REQ-008 SHALL have port imem_ready  input  1  memory accepts the request this cycle (req and ready both high).
REQ-009 SHALL have ports imem_rvalid input 1 / imem_rdata input 32: read response, in order, one per accepted request.
REQ-010 SHALL have ports if_valid output 1, if_pc output 32, if_instr output 32, if_pc_plus4 output 32: fetched instruction to decode.

Function
REQ-011 SHALL keep at most one memory request outstanding.
REQ-012 SHALL implement states IDLE, REQ, WAIT, HOLD.
REQ-013 IDLE: imem_req=0; next cycle go to REQ with imem_addr = current pc.
REQ-014 REQ: imem_req=1, imem_addr=pc held stable until imem_ready=1; on acceptance go to WAIT.
REQ-015 WAIT: on imem_rvalid capture imem_rdata with its pc; if stall=0 present it and issue the next request at pc+4 in the same cycle (back-to-back, state REQ); if stall=1 go to HOLD.
REQ-016 HOLD: if_valid=1 with outputs held constant; when stall drops, instruction is consumed that cycle and state goes to REQ at pc+4.
REQ-017 An instruction SHALL be consumed exactly when if_valid=1 and stall=0; throughput is one instruction per cycle when memory responds in the cycle after acceptance.
REQ-018 if_pc_plus4 SHALL equal if_pc+4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0 without flag).
REQ-019 br_taken=1 in any state SHALL load pc<=new_pc, force if_valid=0 in that same cycle, and go to REQ next cycle.
REQ-020 Redirect during WAIT (or during REQ after acceptance) SHALL set a kill flag; the next imem_rvalid is discarded, and the request to new_pc is not issued until that response returns.
REQ-021 Redirect coinciding with imem_rvalid SHALL discard that response; redirect has priority over stall.
REQ-022 imem_rvalid arriving with no outstanding request SHALL be ignored.

Reset
REQ-023 rst=1 SHALL set state=IDLE, pc=RESET_PC, kill flag=0, imem_req=0, if_valid=0, if_pc=RESET_PC, if_instr=32'h0000_0013 (NOP), if_pc_plus4=RESET_PC+4.
REQ-024 Reset mid-transaction SHALL abandon the outstanding request; its late response SHALL be ignored per REQ-022.

Configuration
REQ-025 Macro FETCH_MISALIGN_TRAP_EN defined: SHALL add output misalign_exc (1 bit), asserted one cycle after a redirect with new_pc[1:0]!=0, with no memory request issued for that target and state IDLE until the next redirect.
REQ-026 Macro not defined: port absent; new_pc[1:0] SHALL be forced to 0 when loaded.

Structure
REQ-027 State encodings, RESET_PC default and the NOP encoding SHALL live in the shared parameters include alongside the BR_* opcodes.
REQ-028 The instruction holding register (capture, hold under stall, kill-discard) SHALL be a sub-module named fetch_buf; the state machine and pc register stay in fetch_ctrl.

Verification
REQ-029 Reset, memory ready=1, 1-cycle response, stall=0 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc follows one cycle later.
REQ-030 stall=1 for 3 cycles while if_instr=32'h00A00093 -> if_valid, if_pc, if_instr constant; no new request; resumes at pc+4.
REQ-031 br_taken=1, new_pc=32'h0000_0100 while in WAIT -> pending response dropped, next imem_addr=32'h100, no instruction from old path reaches decode.
REQ-032 br_taken and imem_rvalid and stall all high in one cycle -> if_valid=0 that cycle, next request 32'h100.
REQ-033 imem_ready held low 5 cycles -> imem_req=1 and imem_addr stable throughout.
REQ-034 With FETCH_MISALIGN_TRAP_EN, redirect to 32'h0000_0102 -> misalign_exc=1 next cycle, imem_req stays 0; without macro -> imem_addr=32'h100.
